// File: rtl/sdr_obj_arbiter.sv
// sdr_obj_arbiter: shares one SDRAM read channel among pixel fetch engines.
// Optional ARB_ROUND_ROBIN_EN selects round-robin grants (default fixed priority).
module sdr_obj_arbiter #(
  parameter int NUM_REQ     = 3,
  parameter int ADDR_W      = 25,
  parameter int REFRESH_LEN = 4,
  parameter int REFRESH_MAX = 512,
  parameter int TIMEOUT     = 64
) (
  input  logic                      clk_ram,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ-1:0]        refresh_hint,
  output logic [NUM_REQ-1:0]        req_rdy,
  output logic [63:0]               req_data,
  output logic [ADDR_W-1:0]         sdr_addr,
  output logic                      sdr_req,
  input  logic                      sdr_rdy,
  input  logic [63:0]               sdr_data,
  output logic                      sdr_refresh,
  output logic                      err_overrun,
  output logic                      err_timeout
);

  localparam int GW   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int TMAX = (TIMEOUT > REFRESH_LEN) ? TIMEOUT : REFRESH_LEN;
  localparam int TW   = $clog2(TMAX + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_REFRESH
  } state_t;

  state_t              state_q, state_d;
  logic [NUM_REQ-1:0]  pend_q, pend_d;
  logic [ADDR_W-1:0]   addr_q [NUM_REQ];
  logic [ADDR_W-1:0]   addr_d [NUM_REQ];
  logic [GW-1:0]       g_q, g_d;
  logic [TW-1:0]       tmr_q, tmr_d;
  logic [9:0]          rcnt_q, rcnt_d;
  logic                gap_q, gap_d;
  logic [NUM_REQ-1:0]  rdy_q, rdy_d;
  logic [63:0]         data_q, data_d;
  logic                ovr_q, ovr_d;
  logic                tmo_q, tmo_d;
  logic [NUM_REQ-1:0]  clr;
  logic [GW-1:0]       gsel;
  logic                rdue;

`ifdef ARB_ROUND_ROBIN_EN
  logic [GW-1:0]       ptr_q, ptr_d;

  // Walk downward so the first pending index after ptr wins last.
  always_comb begin
    gsel = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      if (pend_q[(int'(ptr_q) + k) % NUM_REQ])
        gsel = GW'((int'(ptr_q) + k) % NUM_REQ);
    end
  end
`else
  always_comb begin
    gsel = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (pend_q[i])
        gsel = GW'(i);
    end
  end
`endif

  assign rdue = (rcnt_q >= 10'(REFRESH_MAX));

  always_comb begin
    state_d     = state_q;
    pend_d      = pend_q;
    addr_d      = addr_q;
    g_d         = g_q;
    tmr_d       = tmr_q;
    rcnt_d      = rcnt_q;
    gap_d       = 1'b0;
    rdy_d       = '0;
    data_d      = data_q;
    ovr_d       = ovr_q;
    tmo_d       = tmo_q;
    clr         = '0;
    sdr_req     = 1'b0;
    sdr_addr    = '0;
    sdr_refresh = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
    ptr_d       = ptr_q;
`endif

    if (state_q != S_REFRESH && !rdue)
      rcnt_d = rcnt_q + 10'd1;

    unique case (state_q)
      S_IDLE: begin
        // gap_q holds one idle cycle after each read leaves WAIT
        if (!gap_q) begin
          if (rdue) begin
            state_d = S_REFRESH;
            tmr_d   = '0;
          end else if (|pend_q) begin
            sdr_req  = 1'b1;
            sdr_addr = addr_q[gsel];
            g_d      = gsel;
            tmr_d    = '0;
            state_d  = S_WAIT;
`ifdef ARB_ROUND_ROBIN_EN
            ptr_d    = gsel;
`endif
          end else if (|refresh_hint) begin
            state_d = S_REFRESH;
            tmr_d   = '0;
          end
        end
      end
      S_WAIT: begin
        if (sdr_rdy) begin
          data_d     = sdr_data;
          rdy_d[g_q] = 1'b1;
          clr[g_q]   = 1'b1;
          gap_d      = 1'b1;
          state_d    = S_IDLE;
        end else if (tmr_q == TW'(TIMEOUT - 1)) begin
          clr[g_q] = 1'b1;
          tmo_d    = 1'b1;
          gap_d    = 1'b1;
          state_d  = S_IDLE;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      S_REFRESH: begin
        sdr_refresh = 1'b1;
        rcnt_d      = '0;
        if (tmr_q == TW'(REFRESH_LEN - 1))
          state_d = S_IDLE;
        else
          tmr_d = tmr_q + 1'b1;
      end
      default: state_d = S_IDLE;
    endcase

    // New request beats a same-cycle completion of its predecessor.
    pend_d = pend_q & ~clr;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (req_valid[i]) begin
        if (pend_q[i] && !clr[i])
          ovr_d = 1'b1;
        pend_d[i] = 1'b1;
        addr_d[i] = req_addr[i*ADDR_W +: ADDR_W];
      end
    end
  end

  always_ff @(posedge clk_ram) begin
    if (reset) begin
      state_q <= S_IDLE;
      pend_q  <= '0;
      for (int i = 0; i < NUM_REQ; i++)
        addr_q[i] <= '0;
      g_q     <= '0;
      tmr_q   <= '0;
      rcnt_q  <= '0;
      gap_q   <= 1'b0;
      rdy_q   <= '0;
      data_q  <= '0;
      ovr_q   <= 1'b0;
      tmo_q   <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      ptr_q   <= GW'(NUM_REQ - 1);
`endif
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      addr_q  <= addr_d;
      g_q     <= g_d;
      tmr_q   <= tmr_d;
      rcnt_q  <= rcnt_d;
      gap_q   <= gap_d;
      rdy_q   <= rdy_d;
      data_q  <= data_d;
      ovr_q   <= ovr_d;
      tmo_q   <= tmo_d;
`ifdef ARB_ROUND_ROBIN_EN
      ptr_q   <= ptr_d;
`endif
    end
  end

  assign req_rdy     = rdy_q;
  assign req_data    = data_q;
  assign err_overrun = ovr_q;
  assign err_timeout = tmo_q;

endmodule

// File: tb/tb_sdr_obj_arbiter.sv
// tb_sdr_obj_arbiter: directed tests for the SDRAM read-channel arbiter.
module tb_sdr_obj_arbiter;

  localparam int NR = 3;
  localparam int AW = 25;

  logic            clk_ram = 1'b0;
  logic            reset = 1'b1;
  logic [NR-1:0]   req_valid = '0;
  logic [NR*AW-1:0] req_addr = '0;
  logic [NR-1:0]   refresh_hint = '0;
  logic [NR-1:0]   req_rdy;
  logic [63:0]     req_data;
  logic [AW-1:0]   sdr_addr;
  logic            sdr_req;
  logic            sdr_rdy = 1'b0;
  logic [63:0]     sdr_data = '0;
  logic            sdr_refresh;
  logic            err_overrun;
  logic            err_timeout;

  int errors = 0;
  int checks = 0;

  localparam logic [AW-1:0] A0 = 25'h0000100;
  localparam logic [AW-1:0] A1 = 25'h0000211;
  localparam logic [AW-1:0] A2 = 25'h0000322;

  sdr_obj_arbiter dut (
    .clk_ram      (clk_ram),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_addr     (req_addr),
    .refresh_hint (refresh_hint),
    .req_rdy      (req_rdy),
    .req_data     (req_data),
    .sdr_addr     (sdr_addr),
    .sdr_req      (sdr_req),
    .sdr_rdy      (sdr_rdy),
    .sdr_data     (sdr_data),
    .sdr_refresh  (sdr_refresh),
    .err_overrun  (err_overrun),
    .err_timeout  (err_timeout)
  );

  always #5 clk_ram = ~clk_ram;

  task automatic tick;
    @(posedge clk_ram);
    #1;
  endtask

  task automatic do_reset;
    reset = 1'b1;
    req_valid = '0;
    refresh_hint = '0;
    sdr_rdy = 1'b0;
    tick;
    tick;
    reset = 1'b0;
  endtask

  task automatic set_addr(input int i, input logic [AW-1:0] a);
    req_addr[i*AW +: AW] = a;
  endtask

  // Advance until sdr_req is seen; found=0 if the budget expires.
  task automatic wait_req(output bit found, output logic [AW-1:0] a);
    found = 1'b0;
    a = '0;
    for (int i = 0; i < 200 && !found; i++) begin
      if (sdr_req) begin
        found = 1'b1;
        a = sdr_addr;
      end else begin
        tick;
      end
    end
  endtask

  // Called in the sdr_req cycle: return data in the first WAIT cycle.
  task automatic respond(input logic [63:0] d,
                         output logic [NR-1:0] r,
                         output logic [63:0] q);
    tick;
    sdr_rdy = 1'b1;
    sdr_data = d;
    tick;
    sdr_rdy = 1'b0;
    r = req_rdy;
    q = req_data;
  endtask

  task automatic test_reset;
    do_reset;
    checks++;
    if (req_rdy !== 3'b000) begin
      errors++;
      $display("FAIL reset_rdy got=%b exp=000", req_rdy);
    end
    checks++;
    if ({sdr_req, sdr_refresh, err_overrun, err_timeout} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_flags got=%b exp=0000",
               {sdr_req, sdr_refresh, err_overrun, err_timeout});
    end
    checks++;
    if (sdr_addr !== '0 || req_data !== '0) begin
      errors++;
      $display("FAIL reset_data addr=%h data=%h exp=0", sdr_addr, req_data);
    end
  endtask

  task automatic test_single_read;
    do_reset;
    set_addr(0, 25'h0001230);
    req_valid = 3'b001;
    checks++;
    if (sdr_req !== 1'b0) begin
      errors++;
      $display("FAIL single_early got=%b exp=0", sdr_req);
    end
    tick;
    req_valid = '0;
    checks++;
    if (sdr_req !== 1'b1 || sdr_addr !== 25'h0001230) begin
      errors++;
      $display("FAIL single_req req=%b addr=%h exp=1/0001230", sdr_req, sdr_addr);
    end
    tick;
    checks++;
    if (sdr_req !== 1'b0 || sdr_addr !== '0) begin
      errors++;
      $display("FAIL single_pulse req=%b addr=%h exp=0/0", sdr_req, sdr_addr);
    end
    tick;
    tick;
    sdr_rdy = 1'b1;
    sdr_data = 64'hDEADBEEF_01234567;
    tick;
    sdr_rdy = 1'b0;
    sdr_data = '0;
    checks++;
    if (req_rdy !== 3'b001 || req_data !== 64'hDEADBEEF_01234567) begin
      errors++;
      $display("FAIL single_rdy rdy=%b data=%h exp=001/deadbeef01234567",
               req_rdy, req_data);
    end
    tick;
    checks++;
    if (req_rdy !== 3'b000 || req_data !== 64'hDEADBEEF_01234567) begin
      errors++;
      $display("FAIL single_hold rdy=%b data=%h exp=000/deadbeef01234567",
               req_rdy, req_data);
    end
  endtask

  task automatic test_contention;
    bit f;
    logic [AW-1:0] a;
    logic [NR-1:0] r;
    logic [63:0] q;
    logic [AW-1:0] ea;
    logic [NR-1:0] er;
    do_reset;
    set_addr(0, A0);
    set_addr(1, A1);
    set_addr(2, A2);
    req_valid = 3'b111;
    tick;
    req_valid = '0;
    wait_req(f, a);
    checks++;
    if (!f || a !== A0) begin
      errors++;
      $display("FAIL cont_g0 found=%0d addr=%h exp=%h", f, a, A0);
    end
    respond(64'h11, r, q);
    checks++;
    if (r !== 3'b001 || q !== 64'h11) begin
      errors++;
      $display("FAIL cont_r0 rdy=%b data=%h exp=001/11", r, q);
    end
    checks++;
    if (sdr_req !== 1'b0) begin
      errors++;
      $display("FAIL cont_gap got=%b exp=0", sdr_req);
    end
    tick;
    checks++;
    if (sdr_req !== 1'b1 || sdr_addr !== A1) begin
      errors++;
      $display("FAIL cont_b2b req=%b addr=%h exp=1/%h", sdr_req, sdr_addr, A1);
    end
    respond(64'h22, r, q);
    checks++;
    if (r !== 3'b010 || q !== 64'h22) begin
      errors++;
      $display("FAIL cont_r1 rdy=%b data=%h exp=010/22", r, q);
    end
    req_valid = 3'b001;
    tick;
    req_valid = '0;
`ifdef ARB_ROUND_ROBIN_EN
    ea = A2;
    er = 3'b100;
`else
    ea = A0;
    er = 3'b001;
`endif
    wait_req(f, a);
    checks++;
    if (!f || a !== ea) begin
      errors++;
      $display("FAIL cont_g3 found=%0d addr=%h exp=%h", f, a, ea);
    end
    respond(64'h33, r, q);
    checks++;
    if (r !== er) begin
      errors++;
      $display("FAIL cont_r3 rdy=%b exp=%b", r, er);
    end
`ifdef ARB_ROUND_ROBIN_EN
    ea = A0;
    er = 3'b001;
`else
    ea = A2;
    er = 3'b100;
`endif
    wait_req(f, a);
    checks++;
    if (!f || a !== ea) begin
      errors++;
      $display("FAIL cont_g4 found=%0d addr=%h exp=%h", f, a, ea);
    end
    respond(64'h44, r, q);
    checks++;
    if (r !== er || q !== 64'h44) begin
      errors++;
      $display("FAIL cont_r4 rdy=%b data=%h exp=%b/44", r, q, er);
    end
  endtask

  task automatic test_overrun;
    bit f;
    logic [AW-1:0] a;
    logic [NR-1:0] r;
    logic [63:0] q;
    int extra;
    do_reset;
    set_addr(0, A0);
    req_valid = 3'b001;
    tick;
    req_valid = '0;
    wait_req(f, a);
    tick;
    set_addr(1, 25'h0AAAAAA);
    req_valid = 3'b010;
    tick;
    req_valid = '0;
    checks++;
    if (err_overrun !== 1'b0) begin
      errors++;
      $display("FAIL ovr_first got=%b exp=0", err_overrun);
    end
    set_addr(1, 25'h0BBBBBB);
    req_valid = 3'b010;
    tick;
    req_valid = '0;
    checks++;
    if (err_overrun !== 1'b1) begin
      errors++;
      $display("FAIL ovr_flag got=%b exp=1", err_overrun);
    end
    sdr_rdy = 1'b1;
    sdr_data = 64'h55;
    tick;
    sdr_rdy = 1'b0;
    wait_req(f, a);
    checks++;
    if (!f || a !== 25'h0BBBBBB) begin
      errors++;
      $display("FAIL ovr_addr found=%0d addr=%h exp=0bbbbbb", f, a);
    end
    respond(64'h66, r, q);
    checks++;
    if (r !== 3'b010 || q !== 64'h66) begin
      errors++;
      $display("FAIL ovr_rdy rdy=%b data=%h exp=010/66", r, q);
    end
    extra = 0;
    for (int i = 0; i < 6; i++) begin
      if (sdr_req) extra++;
      tick;
    end
    checks++;
    if (extra !== 0) begin
      errors++;
      $display("FAIL ovr_single extra_reads=%0d exp=0", extra);
    end
  endtask

  task automatic test_refresh;
    int n;
    int w;
    bit seen;
    bit f;
    logic [AW-1:0] a;
    logic [NR-1:0] r;
    logic [63:0] q;
    do_reset;
    n = 0;
    seen = 1'b0;
    for (int i = 0; i < 600 && !seen; i++) begin
      if (sdr_refresh) seen = 1'b1;
      else begin
        n++;
        tick;
      end
    end
    checks++;
    if (!seen || n < 512 || n > 514) begin
      errors++;
      $display("FAIL refresh_due seen=%0d cycles=%0d exp=512..514", seen, n);
    end
    w = 0;
    set_addr(2, A2);
    for (int i = 0; i < 10 && sdr_refresh; i++) begin
      if (sdr_req) w = 100;
      w++;
      req_valid = (i == 1) ? 3'b100 : 3'b000;
      tick;
    end
    req_valid = '0;
    checks++;
    if (w !== 4) begin
      errors++;
      $display("FAIL refresh_len got=%0d exp=4", w);
    end
    checks++;
    if (sdr_req !== 1'b1 || sdr_addr !== A2) begin
      errors++;
      $display("FAIL refresh_after req=%b addr=%h exp=1/%h", sdr_req, sdr_addr, A2);
    end
    respond(64'h77, r, q);
    checks++;
    if (r !== 3'b100) begin
      errors++;
      $display("FAIL refresh_rdy got=%b exp=100", r);
    end
    wait_req(f, a);
    checks++;
    if (f) begin
      errors++;
      $display("FAIL refresh_spurious addr=%h exp=no read", a);
    end
    do_reset;
    tick;
    refresh_hint = 3'b010;
    tick;
    refresh_hint = '0;
    checks++;
    if (sdr_refresh !== 1'b1) begin
      errors++;
      $display("FAIL refresh_hint got=%b exp=1", sdr_refresh);
    end
  endtask

  task automatic test_timeout;
    bit f;
    logic [AW-1:0] a;
    logic [NR-1:0] r;
    logic [NR-1:0] acc;
    logic [63:0] q;
    do_reset;
    set_addr(0, A0);
    set_addr(1, A1);
    req_valid = 3'b011;
    tick;
    req_valid = '0;
    wait_req(f, a);
    acc = '0;
    for (int i = 0; i < 64; i++) begin
      tick;
      acc |= req_rdy;
    end
    checks++;
    if (err_timeout !== 1'b0) begin
      errors++;
      $display("FAIL tmo_early got=%b exp=0", err_timeout);
    end
    tick;
    acc |= req_rdy;
    checks++;
    if (err_timeout !== 1'b1 || acc !== 3'b000) begin
      errors++;
      $display("FAIL tmo_flag err=%b rdy_seen=%b exp=1/000", err_timeout, acc);
    end
    wait_req(f, a);
    checks++;
    if (!f || a !== A1) begin
      errors++;
      $display("FAIL tmo_next found=%0d addr=%h exp=%h", f, a, A1);
    end
    respond(64'h88, r, q);
    checks++;
    if (r !== 3'b010 || q !== 64'h88) begin
      errors++;
      $display("FAIL tmo_rdy rdy=%b data=%h exp=010/88", r, q);
    end
  endtask

  task automatic test_reset_mid_wait;
    bit f;
    logic [AW-1:0] a;
    logic [NR-1:0] acc;
    int reads;
    do_reset;
    set_addr(2, A2);
    req_valid = 3'b100;
    tick;
    req_valid = '0;
    wait_req(f, a);
    tick;
    reset = 1'b1;
    tick;
    tick;
    reset = 1'b0;
    sdr_rdy = 1'b1;
    sdr_data = 64'hCAFE;
    tick;
    sdr_rdy = 1'b0;
    acc = '0;
    reads = 0;
    for (int i = 0; i < 5; i++) begin
      acc |= req_rdy;
      if (sdr_req) reads++;
      tick;
    end
    checks++;
    if (acc !== 3'b000 || reads !== 0) begin
      errors++;
      $display("FAIL rst_wait_rdy rdy_seen=%b reads=%0d exp=000/0", acc, reads);
    end
    checks++;
    if (req_data !== '0 || sdr_refresh !== 1'b0 || err_timeout !== 1'b0
        || err_overrun !== 1'b0) begin
      errors++;
      $display("FAIL rst_wait_out data=%h ref=%b tmo=%b ovr=%b exp=0",
               req_data, sdr_refresh, err_timeout, err_overrun);
    end
  endtask

  initial begin
    test_reset;
    test_single_read;
    test_contention;
    test_overrun;
    test_refresh;
    test_timeout;
    test_reset_mid_wait;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sdr_obj_arbiter.md
# sdr_obj_arbiter

Shares one 64-bit SDRAM read channel between the sprite line fetcher and the other pixel-side fetch engines (tile layers, palette loader). It latches one single-cycle request per requester, grants one at a time, drives the SDRAM request/address, returns data with a per-requester ready pulse, and schedules SDRAM refresh windows so that no two sources ever collide on the channel. It sits between the video fetch engines and the SDRAM controller port, entirely in the clk_ram domain.

## Interface
- NUM_REQ, 3, number of requesters; index 0 = sprite fetcher.
- ADDR_W, 25, SDRAM word address width.
- REFRESH_LEN, 4, clk_ram cycles sdr_refresh is held per refresh window.
- REFRESH_MAX, 512, maximum idle-free cycles before a refresh is forced.
- TIMEOUT, 64, WAIT cycles before an outstanding read is aborted.

- clk_ram  in  1  memory clock; all logic is on its rising edge.
- reset  in  1  reset, synchronous, active-high; clock clk_ram.
- req_valid  in  NUM_REQ  per-requester one-cycle request pulse.
- req_addr  in  NUM_REQ*ADDR_W  request address; slice i belongs to requester i and is sampled with req_valid[i].
- refresh_hint  in  NUM_REQ  requester signals that the channel may be refreshed now.
- req_rdy  out  NUM_REQ  one-cycle pulse; read for requester i is complete.
- req_data  out  64  read data; valid while req_rdy is high, held until the next completion.
- sdr_addr  out  ADDR_W  address to the SDRAM controller.
- sdr_req  out  1  one-cycle read strobe.
- sdr_rdy  in  1  controller data-valid strobe.
- sdr_data  in  64  controller read data.
- sdr_refresh  out  1  refresh window level.
- err_overrun  out  1  sticky; a request arrived while that requester's previous request was still pending.
- err_timeout  out  1  sticky; a read was aborted.

## Operation
- Pending latch per requester: req_valid[i] sets pend[i] and captures addr[i]. If pend[i] is already set, the new address overwrites the old one and err_overrun sets. A request arriving in the same cycle its predecessor completes becomes a new pending request.
- FSM states: IDLE, WAIT, REFRESH.
- IDLE, priority order: (1) refresh counter ≥ REFRESH_MAX -> REFRESH; (2) any pend -> select grant g, drive sdr_addr=addr[g], pulse sdr_req, go to WAIT; (3) no pend and any refresh_hint -> REFRESH; (4) otherwise stay in IDLE.
- Grant selection: fixed priority, lowest index wins, unless ARB_ROUND_ROBIN_EN is defined.
- WAIT: sdr_rdy is ignored in the cycle sdr_req is high. On a later sdr_rdy: register sdr_data into req_data, pulse req_rdy[g], clear pend[g], go to IDLE. If TIMEOUT cycles pass without sdr_rdy: clear pend[g], set err_timeout, give no req_rdy, go to IDLE.
- REFRESH: sdr_refresh is high for exactly REFRESH_LEN cycles, the refresh counter clears, then the FSM returns to IDLE. Requests that arrive during the window remain pending.
- Refresh counter: 10 bits, saturates at REFRESH_MAX, increments every cycle the FSM is not in REFRESH.
- Reset: FSM goes to IDLE. pend, req_rdy, sdr_req, sdr_refresh, err_* = 0. sdr_addr, req_data = 0. Counters = 0. RR pointer = NUM_REQ-1.
- Reset during WAIT drops the outstanding read. A later stray sdr_rdy in IDLE is ignored.

## Timing
- req_valid high in cycle N -> pend set at edge N+1 -> with the FSM in IDLE and no refresh due, sdr_req is high in cycle N+1, for exactly one cycle.
- sdr_rdy sampled in cycle M -> req_rdy and req_data valid in cycle M+1.
- At most one read is outstanding at any time. sdr_req and sdr_refresh are never high in the same cycle.
- Back-to-back: after a completion the next grant issues one cycle after req_rdy (IDLE cycle). Minimum 3 cycles per read plus controller latency.

## Configuration
- ARB_ROUND_ROBIN_EN defined: grant is the first pending requester after the last granted one, cyclically. The pointer updates on each grant.
- ARB_ROUND_ROBIN_EN undefined: fixed priority, index 0 highest. The pointer logic is absent.

## Test plan
- Single read: req_valid[0] with addr 0x000_1230, controller returns 0xDEADBEEF_01234567 three cycles after sdr_req -> sdr_addr=0x0001230 for one cycle, req_rdy=3'b001 one cycle later with that data.
- Contention: req_valid=3'b111 in the same cycle. Fixed priority -> grants in order 0,1,2. With ARB_ROUND_ROBIN_EN and a repeated all-request pattern -> 0,1,2,0,1,2.
- Overrun: two req_valid[1] pulses with addresses A then B before the grant -> a single read to B, err_overrun=1.
- Refresh: no requests for REFRESH_MAX cycles -> sdr_refresh high for exactly 4 cycles. A req_valid[2] during the window -> sdr_req issues right after the window.
- Timeout: sdr_rdy withheld -> after 64 WAIT cycles err_timeout=1, no req_rdy, the next pending request is granted.
- Reset mid-WAIT: reset asserted while WAIT, sdr_rdy pulsed afterwards -> all outputs 0 and no req_rdy.
